// File: rtl/rnand_meta_pipe.sv
// rtl/rnand_meta_pipe.sv - multi-channel NAND/AND/NOR/XNOR array behind an elastic valid/ready pipeline
// Each channel's result is computed at acceptance; only {valid, mode, result} travels down the stages.
module rnand_meta_pipe #(
    parameter int width_p       = 8,
    parameter int els_p         = 4,
    parameter int stages_p      = 2,
    parameter int count_width_p = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       v_i,
    output logic                       ready_o,
    input  logic [1:0]                 mode_i,
    input  logic [els_p-1:0]           en_i,
    input  logic [els_p*width_p-1:0]   data_a_i,
    input  logic [els_p*width_p-1:0]   data_b_i,
    output logic                       v_o,
    output logic [els_p*width_p-1:0]   data_o,
    output logic [1:0]                 mode_o,
    input  logic                       yumi_i,
    output logic [count_width_p-1:0]   count_o
);

    localparam int dw_lp = els_p * width_p;

    logic [dw_lp-1:0]                  w_res;
    logic [stages_p-1:0]               w_adv;
    logic                              w_accept;
    logic [stages_p-1:0]               r_valid;
    logic [stages_p-1:0][1:0]          r_mode;
    logic [stages_p-1:0][dw_lp-1:0]    r_data;
    logic [count_width_p-1:0]          r_count;

    always_comb begin
        w_res = '0;
        for (int k = 0; k < els_p; k++) begin
            if (en_i[k]) begin
                case (mode_i)
                    2'd0:    w_res[k*width_p +: width_p] = ~(data_a_i[k*width_p +: width_p] & data_b_i[k*width_p +: width_p]);
                    2'd1:    w_res[k*width_p +: width_p] =   data_a_i[k*width_p +: width_p] & data_b_i[k*width_p +: width_p];
                    2'd2:    w_res[k*width_p +: width_p] = ~(data_a_i[k*width_p +: width_p] | data_b_i[k*width_p +: width_p]);
                    default: w_res[k*width_p +: width_p] = ~(data_a_i[k*width_p +: width_p] ^ data_b_i[k*width_p +: width_p]);
                endcase
            end
        end
    end

    // A stage moves when some slot downstream of it is empty or the consumer is taking the head;
    // scanning from the output end avoids a combinational self-loop through the advance vector.
    always_comb begin
        logic v_free;
        w_adv  = '0;
        v_free = yumi_i;
        for (int i = stages_p - 1; i >= 0; i--) begin
            w_adv[i] = r_valid[i] & v_free;
            v_free   = v_free | ~r_valid[i];
        end
    end

    assign ready_o  = ~r_valid[0] | w_adv[0];
    assign w_accept = v_i & ready_o;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_valid[0] <= 1'b0;
            r_mode[0]  <= 2'd0;
            r_data[0]  <= '0;
        end else if (w_accept) begin
            r_valid[0] <= 1'b1;
            r_mode[0]  <= mode_i;
            r_data[0]  <= w_res;
        end else if (w_adv[0]) begin
            r_valid[0] <= 1'b0;
        end
    end

    for (genvar i = 1; i < stages_p; i++) begin : g_stage
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                r_valid[i] <= 1'b0;
                r_mode[i]  <= 2'd0;
                r_data[i]  <= '0;
            end else if (w_adv[i-1]) begin
                r_valid[i] <= 1'b1;
                r_mode[i]  <= r_mode[i-1];
                r_data[i]  <= r_data[i-1];
            end else if (w_adv[i]) begin
                r_valid[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_count <= '0;
        end else if (yumi_i) begin
            r_count <= r_count + count_width_p'(1);
        end
    end

    assign v_o     = r_valid[stages_p-1];
    assign mode_o  = r_mode[stages_p-1];
    assign data_o  = r_data[stages_p-1];
    assign count_o = r_count;

endmodule

// File: tb/tb_rnand_meta_pipe.sv
// tb/tb_rnand_meta_pipe.sv - scoreboard bench for rnand_meta_pipe
module tb_rnand_meta_pipe;

    localparam int W  = 8;
    localparam int E  = 4;
    localparam int S  = 2;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            v_i = 1'b0;
    logic            ready_o;
    logic [1:0]      mode_i = 2'd0;
    logic [E-1:0]    en_i = '0;
    logic [E*W-1:0]  a = '0;
    logic [E*W-1:0]  b = '0;
    logic            v_o;
    logic [E*W-1:0]  data_o;
    logic [1:0]      mode_o;
    logic            yumi;
    logic            yumi_en = 1'b0;
    logic [CW-1:0]   count_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [33:0] exp_q[$];
    int pop_cyc[$];

    assign yumi = yumi_en & v_o;

    rnand_meta_pipe #(.width_p(W), .els_p(E), .stages_p(S), .count_width_p(CW)) dut (
        .clk_i(clk), .reset_i(rst), .v_i(v_i), .ready_o(ready_o), .mode_i(mode_i),
        .en_i(en_i), .data_a_i(a), .data_b_i(b), .v_o(v_o), .data_o(data_o),
        .mode_o(mode_o), .yumi_i(yumi), .count_o(count_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && v_o && yumi) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h expected none", data_o);
            end else begin
                chk("result", 64'({mode_o, data_o}), 64'(exp_q.pop_front()));
                pop_cyc.push_back(cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            assert (!(yumi && !v_o)) else begin
                errors++;
                $display("FAIL yumi_without_valid: got v_o=0 expected 1");
            end
        end
    end

    task automatic send(input logic [1:0] m, input logic [3:0] e, input logic [31:0] da,
                        input logic [31:0] db, input logic [31:0] ex);
        int t = 0;
        v_i = 1'b1; mode_i = m; en_i = e; a = da; b = db;
        #1;
        while (!ready_o && t < 50) begin
            @(posedge clk); #2; t++;
        end
        if (!ready_o) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got ready_o=0 expected 1");
            v_i = 1'b0;
            return;
        end
        exp_q.push_back({m, ex});
        @(posedge clk); #1;
        v_i = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || v_o) && t < 100) begin
            @(negedge clk); t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #2;
        chk("rst_v_o",     64'(v_o),     64'(0));
        chk("rst_data_o",  64'(data_o),  64'(0));
        chk("rst_mode_o",  64'(mode_o),  64'(0));
        chk("rst_count_o", 64'(count_o), 64'(0));
        chk("rst_ready_o", 64'(ready_o), 64'(1));
        @(negedge clk);
        rst = 1'b0;
        yumi_en = 1'b1;

        send(2'd0, 4'hF, 32'hFF00_F0AA, 32'h0F0F_FF55, 32'hF0FF_0FFF);
        chk("nand_lat_early", 64'(v_o), 64'(0));
        @(posedge clk); #1;
        chk("nand_lat_visible", 64'(v_o), 64'(1));
        drain();
        chk("count_after_nand", 64'(count_o), 64'(1));

        pop_cyc.delete();
        send(2'd0, 4'hF, 32'h0000_00FF, 32'h0000_00FF, 32'hFFFF_FF00);
        send(2'd1, 4'hF, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_00FF);
        send(2'd2, 4'hF, 32'h0000_00FF, 32'h0000_00FF, 32'hFFFF_FF00);
        send(2'd3, 4'hF, 32'h0000_00FF, 32'h0000_00FF, 32'hFFFF_FFFF);
        drain();
        chk("sweep_pops", 64'(pop_cyc.size()), 64'(4));
        if (pop_cyc.size() >= 4) chk("sweep_no_bubble", 64'(pop_cyc[3] - pop_cyc[0]), 64'(3));
        chk("count_after_sweep", 64'(count_o), 64'(5));

        yumi_en = 1'b0;
        pop_cyc.delete();
        send(2'd1, 4'hF, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678);
        send(2'd0, 4'hF, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h0F0F_0F0F);
        v_i = 1'b1; mode_i = 2'd3; en_i = 4'hF; a = 32'hA5A5_A5A5; b = 32'hA5A5_0000;
        #1;
        chk("bp_ready_full", 64'(ready_o), 64'(0));
        @(posedge clk); #1;
        chk("bp_ready_hold", 64'(ready_o), 64'(0));
        chk("bp_head_mode", 64'(mode_o), 64'(1));
        yumi_en = 1'b1;
        #1;
        chk("bp_ready_yumi", 64'(ready_o), 64'(1));
        exp_q.push_back({2'd3, 32'hFFFF_5A5A});
        @(posedge clk); #1;
        v_i = 1'b0;
        drain();
        chk("bp_pops", 64'(pop_cyc.size()), 64'(3));
        chk("count_after_bp", 64'(count_o), 64'(8));

        send(2'd3, 4'b0101, 32'h0, 32'h0, 32'h00FF_00FF);
        drain();
        chk("count_after_en", 64'(count_o), 64'(9));

        for (int i = 0; i < 6; i++) begin
            logic [7:0]  bt;
            logic [31:0] pat;
            bt  = 8'(i * 17);
            pat = {bt, bt, bt, bt};
            if (i % 2 == 0) send(2'd1, 4'hF, pat, pat, pat);
            else            send(2'd3, 4'hF, pat, pat, 32'hFFFF_FFFF);
        end
        drain();
        chk("count_15", 64'(count_o), 64'(15));
        send(2'd2, 4'hF, 32'h0F0F_0F0F, 32'hF000_000F, 32'h00F0_F0F0);
        drain();
        chk("count_wrap_0", 64'(count_o), 64'(0));
        send(2'd0, 4'hF, 32'hFFFF_FFFF, 32'h00FF_FF00, 32'hFF00_00FF);
        drain();
        chk("count_wrap_1", 64'(count_o), 64'(1));

        yumi_en = 1'b0;
        send(2'd1, 4'hF, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678);
        send(2'd0, 4'hF, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h0F0F_0F0F);
        #2;
        chk("mid_full_v_o", 64'(v_o), 64'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_v_o",     64'(v_o),     64'(0));
        chk("mid_rst_data_o",  64'(data_o),  64'(0));
        chk("mid_rst_mode_o",  64'(mode_o),  64'(0));
        chk("mid_rst_count_o", 64'(count_o), 64'(0));
        chk("mid_rst_ready_o", 64'(ready_o), 64'(1));
        exp_q.delete();
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b0;
        yumi_en = 1'b1;
        @(negedge clk);
        send(2'd0, 4'hF, 32'hFF00_F0AA, 32'h0F0F_FF55, 32'hF0FF_0FFF);
        chk("post_rst_lat_early", 64'(v_o), 64'(0));
        @(posedge clk); #1;
        chk("post_rst_lat_visible", 64'(v_o), 64'(1));
        drain();
        chk("post_rst_count", 64'(count_o), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
